// File: rtl/uart_defs.sv
// Shared definitions for the UART transmit arbiter.
//   UART_DATA_W : width of one UART data byte
//   arb_state_e : arbiter FSM state encoding (Idle=0, WaitBusy=1, WaitDone=2, Hold=3)
package uart_defs;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitBusy = 2'd1,
    StWaitDone = 2'd2,
    StHold     = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector.
//   req_i     : request vector, one bit per requester
//   ptr_i     : index where the upward search starts (wraps modulo NUM_REQ)
//   mask_en_i : when set, only the requester at ptr_i may win
//   idx_o     : index of the winning requester (0 when valid_o is low)
//   valid_o   : a winner exists
module uart_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  input  logic               mask_en_i,
  output logic [PTR_W-1:0]   idx_o,
  output logic               valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      logic [PTR_W-1:0] w_cand;
      w_cand = PTR_W'((32'(ptr_i) + i) % NUM_REQ);
      // Masked search only considers the starting slot (i == 0).
      if (!valid_o && req_i[w_cand] && (!mask_en_i || (i == 0))) begin
        valid_o = 1'b1;
        idx_o   = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
//   sys_clk_i   : system clock
//   sys_rst_i   : asynchronous active-high reset
//   req_i       : per-requester byte valid
//   dat_i       : byte k at [8k+7:8k]
//   last_i      : byte k ends its packet; 0 requests a lock on the transmitter
//   ack_o       : one-cycle pulse, byte k captured
//   grant_o     : one-hot current owner
//   timeout_o   : one-cycle pulse on busy-rise or hold watchdog expiry
//   uart_wr_o   : one-cycle write strobe to the UART
//   uart_dat_o  : byte to the UART, held from issue until the next issue
//   uart_busy_i : UART frame in progress
module uart_tx_arbiter
  import uart_defs::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                           sys_clk_i,
  input  logic                           sys_rst_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [UART_DATA_W*NUM_REQ-1:0] dat_i,
  input  logic [NUM_REQ-1:0]             last_i,
  output logic [NUM_REQ-1:0]             ack_o,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic                           timeout_o,
  output logic                           uart_wr_o,
  output logic [UART_DATA_W-1:0]         uart_dat_o,
  input  logic                           uart_busy_i
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  // State and capture registers
  arb_state_e             r_state;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       r_owner;
  logic                   r_lock;
  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_REQ-1:0]     r_ack;
  logic [NUM_REQ-1:0]     r_grant;
  logic                   r_timeout;
  logic                   r_wr;
  logic [UART_DATA_W-1:0] r_dat;

  // Next-state values
  arb_state_e             w_state_nxt;
  logic [PTR_W-1:0]       w_ptr_nxt;
  logic [PTR_W-1:0]       w_owner_nxt;
  logic                   w_lock_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [NUM_REQ-1:0]     w_ack_nxt;
  logic [NUM_REQ-1:0]     w_grant_nxt;
  logic                   w_timeout_nxt;
  logic                   w_wr_nxt;
  logic [UART_DATA_W-1:0] w_dat_nxt;

  // Selector interface and decoded events
  logic [PTR_W-1:0]       w_pick_ptr;
  logic                   w_pick_mask;
  logic [PTR_W-1:0]       w_pick_idx;
  logic                   w_pick_valid;
  logic [UART_DATA_W-1:0] w_pick_dat;
  logic                   w_pick_last;
  logic                   w_cnt_last;
  logic                   w_issue;
  logic                   w_release;
  logic [PTR_W-1:0]       w_ptr_after_owner;

  // In HOLD the search is pinned to the owner so other requests cannot win.
  assign w_pick_mask = (r_state == StHold);
  assign w_pick_ptr  = w_pick_mask ? r_owner : r_ptr;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req_i     (req_i),
    .ptr_i     (w_pick_ptr),
    .mask_en_i (w_pick_mask),
    .idx_o     (w_pick_idx),
    .valid_o   (w_pick_valid)
  );

  // Byte and last flag of the selected requester
  always_comb begin
    w_pick_dat = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (PTR_W'(k) == w_pick_idx) begin
        w_pick_dat = dat_i[k*UART_DATA_W +: UART_DATA_W];
      end
    end
  end

  assign w_pick_last       = last_i[w_pick_idx];
  assign w_cnt_last        = (r_cnt == CNT_LAST);
  assign w_ptr_after_owner = (r_owner == PTR_LAST) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_lock_nxt    = r_lock;
    w_cnt_nxt     = r_cnt;
    w_ack_nxt     = '0;
    w_grant_nxt   = r_grant;
    w_timeout_nxt = 1'b0;
    w_wr_nxt      = 1'b0;
    w_dat_nxt     = r_dat;
    w_issue       = 1'b0;
    w_release     = 1'b0;

    case (r_state)
      StIdle: begin
        if (!uart_busy_i && w_pick_valid) begin
          w_issue = 1'b1;
        end
      end
      StWaitBusy: begin
        if (uart_busy_i) begin
          w_state_nxt = StWaitDone;
        end else if (w_cnt_last) begin
          // UART never accepted the byte; it was already acked and is dropped.
          w_release     = 1'b1;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StWaitDone: begin
        if (!uart_busy_i) begin
          if (r_lock) begin
            w_state_nxt = StHold;
            w_cnt_nxt   = '0;
          end else begin
            w_release = 1'b1;
          end
        end
      end
      StHold: begin
        if (w_pick_valid) begin
          w_issue = 1'b1;
        end else if (w_cnt_last) begin
          w_release     = 1'b1;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    if (w_issue) begin
      w_state_nxt             = StWaitBusy;
      w_cnt_nxt               = '0;
      w_owner_nxt             = w_pick_idx;
      w_dat_nxt               = w_pick_dat;
      w_lock_nxt              = !w_pick_last;
      w_ack_nxt[w_pick_idx]   = 1'b1;
      w_grant_nxt             = '0;
      w_grant_nxt[w_pick_idx] = 1'b1;
      w_wr_nxt                = 1'b1;
    end

    if (w_release) begin
      w_state_nxt = StIdle;
      w_lock_nxt  = 1'b0;
      w_grant_nxt = '0;
      w_ptr_nxt   = w_ptr_after_owner;
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_state   <= StIdle;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_lock    <= 1'b0;
      r_cnt     <= '0;
      r_ack     <= '0;
      r_grant   <= '0;
      r_timeout <= 1'b0;
      r_wr      <= 1'b0;
      r_dat     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_lock    <= w_lock_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ack     <= w_ack_nxt;
      r_grant   <= w_grant_nxt;
      r_timeout <= w_timeout_nxt;
      r_wr      <= w_wr_nxt;
      r_dat     <= w_dat_nxt;
    end
  end

  assign ack_o      = r_ack;
  assign grant_o    = r_grant;
  assign timeout_o  = r_timeout;
  assign uart_wr_o  = r_wr;
  assign uart_dat_o = r_dat;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural UART busy model,
// queue-driven requesters and a scoreboard monitor.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NR-1:0] req_i;
  logic [8*NR-1:0] dat_i;
  logic [NR-1:0] last_i;
  logic [NR-1:0] ack_o;
  logic [NR-1:0] grant_o;
  logic          timeout_o;
  logic          uart_wr_o;
  logic [7:0]    uart_dat_o;
  logic          uart_busy_i;

  always #10 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ (NR),
    .TIMEOUT (TO)
  ) dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst),
    .req_i       (req_i),
    .dat_i       (dat_i),
    .last_i      (last_i),
    .ack_o       (ack_o),
    .grant_o     (grant_o),
    .timeout_o   (timeout_o),
    .uart_wr_o   (uart_wr_o),
    .uart_dat_o  (uart_dat_o),
    .uart_busy_i (uart_busy_i)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] exp_q [NR][$];   // bytes presented, awaiting their UART write
  logic [8:0] src_q [NR][$];   // {last, byte} still to be presented
  int         exp_to [$];      // cycles in which timeout_o must pulse
  int         gap [NR];
  int         busy_cnt;
  bit         pend, busy_hold, uart_alive, rand_gap;

  // Reference model: round-robin pointer and lock owner
  int            mdl_ptr, mdl_owner;
  bit            mdl_locked;
  logic [NR-1:0] prev_req, prev_last;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor / scoreboard
  initial forever begin
    int w;
    @(negedge clk);
    if (rst) begin
      mdl_ptr    = 0;
      mdl_locked = 0;
      exp_to.delete();
    end else begin
      if (timeout_o) begin
        if (exp_to.size() == 0) fail_now("timeout_unexpected");
        else chk("timeout_cycle", 32'(cyc), 32'(exp_to.pop_front()));
        chk("grant_after_timeout", 32'(grant_o), 32'd0);
        mdl_locked = 0;
      end
      if (uart_wr_o || (ack_o != '0)) begin
        w = -1;
        if (mdl_locked) w = mdl_owner;
        else begin
          for (int i = 0; i < NR; i++) begin
            int j;
            j = (mdl_ptr + i) % NR;
            if (w < 0 && prev_req[j]) w = j;
          end
        end
        if (w < 0) fail_now("issue_without_request");
        else begin
          chk("uart_wr", 32'(uart_wr_o), 32'd1);
          chk("ack_onehot", 32'(ack_o), 32'd1 << w);
          chk("grant_onehot", 32'(grant_o), 32'd1 << w);
          if (exp_q[w].size() == 0) fail_now("uart_dat_unexpected");
          else chk("uart_dat", 32'(uart_dat_o), 32'(exp_q[w].pop_front()));
          mdl_owner  = w;
          mdl_locked = !prev_last[w];
          mdl_ptr    = (w + 1) % NR;
          if (!uart_alive) exp_to.push_back(cyc + TO);
        end
      end
      if (mdl_locked) chk("grant_held", 32'(grant_o), 32'd1 << mdl_owner);
    end
    prev_req  = req_i;
    prev_last = last_i;
  end

  task automatic present(input int k);
    logic [8:0] it;
    it = src_q[k].pop_front();
    dat_i[8*k +: 8] = it[7:0];
    last_i[k]       = it[8];
    req_i[k]        = 1'b1;
    exp_q[k].push_back(it[7:0]);
  endtask

  // One clock: requesters react to ack, then the UART busy model advances.
  task automatic step();
    logic prev_busy;
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (req_i[k] && ack_o[k]) begin
        if (!last_i[k] && src_q[k].size() > 0) present(k);
        else begin
          req_i[k] = 1'b0;
          gap[k]   = rand_gap ? int'($urandom_range(3, 0)) : 0;
        end
      end else if (!req_i[k]) begin
        if (gap[k] > 0) gap[k]--;
        else if (src_q[k].size() > 0) present(k);
      end
    end
    prev_busy = uart_busy_i;
    if (busy_cnt > 0) busy_cnt--;
    if (pend) begin
      busy_cnt = int'($urandom_range(6, 2));
      pend     = 0;
    end
    if (uart_wr_o && uart_alive) pend = 1;
    uart_busy_i = busy_hold || (busy_cnt > 0);
    // A locked owner with nothing left to send must hit the hold watchdog.
    if (prev_busy && !uart_busy_i && mdl_locked && !req_i[mdl_owner] &&
        src_q[mdl_owner].size() == 0)
      exp_to.push_back(cyc + TO + 1);
  endtask

  function automatic bit quiet();
    bit q;
    q = (req_i == '0) && !uart_busy_i && !pend && (grant_o == '0) && (exp_to.size() == 0);
    for (int k = 0; k < NR; k++) q = q && (src_q[k].size() == 0) && (exp_q[k].size() == 0);
    return q;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!quiet() && n < budget);
    if (!quiet()) fail_now("drain_budget");
    repeat (2) step();
  endtask

  initial begin
    int n;
    req_i = '0; dat_i = '0; last_i = '0; uart_busy_i = 1'b0;
    busy_cnt = 0; pend = 0; busy_hold = 0; uart_alive = 1; rand_gap = 0;
    mdl_ptr = 0; mdl_owner = 0; mdl_locked = 0; prev_req = '0; prev_last = '0;
    for (int k = 0; k < NR; k++) gap[k] = 0;

    #1 rst = 1'b1;
    #4;
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_wr", 32'(uart_wr_o), 32'd0);
    chk("rst_dat", 32'(uart_dat_o), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("idle_no_wr", 32'(uart_wr_o), 32'd0);

    // Single byte
    src_q[0].push_back({1'b1, 8'hFE});
    drain(200);

    // Contention: two requests in the same cycle
    src_q[1].push_back({1'b1, 8'h11});
    src_q[3].push_back({1'b1, 8'h33});
    drain(200);

    // Locked packet with another requester pending
    src_q[2].push_back({1'b0, 8'h41});
    src_q[2].push_back({1'b0, 8'h42});
    src_q[2].push_back({1'b1, 8'h43});
    repeat (2) step();
    src_q[0].push_back({1'b1, 8'h55});
    drain(300);

    // Busy-rise watchdog: UART never goes busy for the first byte
    uart_alive = 0;
    src_q[0].push_back({1'b1, 8'hA5});
    src_q[2].push_back({1'b1, 8'h77});
    n = 0;
    do begin
      step();
      n++;
    end while (!uart_wr_o && n < 50);
    if (!uart_wr_o) fail_now("busy_to_first_issue");
    repeat (3) step();
    uart_alive = 1;
    drain(300);

    // Hold watchdog: owner locks then goes silent
    src_q[1].push_back({1'b0, 8'h20});
    drain(300);
    src_q[0].push_back({1'b1, 8'h0A});
    src_q[3].push_back({1'b1, 8'h3A});
    drain(200);

    // Reset while waiting for the frame to finish
    src_q[1].push_back({1'b1, 8'h99});
    n = 0;
    do begin
      step();
      n++;
    end while (!uart_wr_o && n < 50);
    if (!uart_wr_o) fail_now("reset_test_issue");
    busy_hold = 1;
    repeat (4) step();
    src_q[3].push_back({1'b1, 8'h3C});
    step();
    #4 rst = 1'b1;
    #1;
    chk("async_rst_grant", 32'(grant_o), 32'd0);
    chk("async_rst_ack", 32'(ack_o), 32'd0);
    chk("async_rst_timeout", 32'(timeout_o), 32'd0);
    chk("async_rst_wr", 32'(uart_wr_o), 32'd0);
    chk("async_rst_dat", 32'(uart_dat_o), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (5) begin
      step();
      chk("no_wr_while_busy", 32'(uart_wr_o), 32'd0);
    end
    busy_hold = 0;
    drain(200);

    // Randomized packets from all requesters
    rand_gap = 1;
    for (int k = 0; k < NR; k++) begin
      for (int p = 0; p < 6; p++) begin
        int len;
        len = int'($urandom_range(3, 1));
        for (int b = 0; b < len; b++) begin
          logic [7:0] v;
          v = 8'($urandom);
          src_q[k].push_back({(b == len - 1), v});
        end
      end
    end
    drain(20000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single `uart` transmitter among `NUM_REQ` byte producers. Each producer presents one byte at a time with a req/ack handshake. The arbiter issues a one-cycle write strobe to the UART, then tracks `uart_busy` until the frame completes. A requester may lock the transmitter for a multi-byte packet by holding `last` low. Watchdog timeouts guard against a UART that never goes busy and against a lock owner that stalls.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `TIMEOUT`, 16: cycle limit for the busy-rise wait and the lock hold wait, ≥2.

Ports:
- `sys_clk_i` in 1: system clock.
- `sys_rst_i` in 1: reset, asynchronous, active-high.
- `req_i` in NUM_REQ: per-requester byte valid.
- `dat_i` in 8*NUM_REQ: byte k at `[8k+7:8k]`.
- `last_i` in NUM_REQ: byte k ends its packet; 0 requests lock.
- `ack_o` out NUM_REQ: one-cycle pulse, byte k captured.
- `grant_o` out NUM_REQ: one-hot current owner.
- `timeout_o` out 1: one-cycle pulse on either watchdog expiry.
- `uart_wr_o` out 1: to `uart_wr_i`.
- `uart_dat_o` out 8: to `uart_dat_i`, held from issue until the next issue.
- `uart_busy_i` in 1: from `uart_busy`.

## Operation
- States: IDLE, WAIT_BUSY, WAIT_DONE, HOLD.
- IDLE:
  - Condition: `uart_busy_i`=0 and any `req_i`=1.
  - Winner: the first set request searching upward from `ptr`, wrapping modulo NUM_REQ.
  - Capture: winner index, `dat_i` slice, and `last_i` bit into `lock`=!last.
  - Outputs: assert `grant_o`, `ack_o[w]`, and `uart_wr_o`.
  - Next state: WAIT_BUSY, with counter cleared.
- WAIT_BUSY:
  - `uart_busy_i`=1: go to WAIT_DONE.
  - Counter reaches TIMEOUT-1 with no busy: pulse `timeout_o`, clear `lock` and `grant_o`, set `ptr`=w+1, go to IDLE. The byte is lost; it was already acked.
- WAIT_DONE: on `uart_busy_i`=0:
  - `lock`=0: clear `grant_o`, set `ptr`=w+1, go to IDLE.
  - `lock`=1: go to HOLD, with counter cleared.
- HOLD: the owner has exclusive access.
  - `req_i[w]`=1: capture byte and last, pulse `ack_o[w]`/`uart_wr_o`, go to WAIT_BUSY.
  - Other requests are ignored.
  - Counter reaches TIMEOUT-1: pulse `timeout_o`, release as above, go to IDLE.
- Requester rule: on the edge where `ack_o[k]`=1 is sampled, update `dat_i`/`last_i` or drop `req_i`. The arbiter does not resample for at least 2 cycles.
- Widths:
  - `ptr`: `$clog2(NUM_REQ)`, wraps NUM_REQ-1→0.
  - Counter: `$clog2(TIMEOUT)`, saturates; never wraps.
- Simultaneous requests are resolved by `ptr` only. A request arriving in the issue cycle waits for the next IDLE/HOLD decision.
- Reset mid-operation:
  - All state is cleared asynchronously and `uart_wr_o` drops immediately.
  - After release, IDLE waits for `uart_busy_i`=0 before the first issue.

## Timing
- Reset values: `ack_o`=0, `grant_o`=0, `timeout_o`=0, `uart_wr_o`=0, `uart_dat_o`=0x00. Internally, state=IDLE, `ptr`=0, `lock`=0, counter=0.
- All outputs are registered.
- Issue latency: 1 cycle. When a decision edge finds a qualifying request, `uart_wr_o`, `ack_o`, and `grant_o` are high in the following cycle. `uart_wr_o` and `ack_o` last exactly one cycle.
- `grant_o` stays high from the issue cycle until the cycle after release.
- Locked back-to-back: the next `uart_wr_o` comes 2 cycles after the edge that sees `uart_busy_i` fall, provided `req_i[w]` is already high.
- Minimum gap between releases and the next issue to another requester: 1 IDLE cycle.

## Structure
- Shared include/package `uart_defs`:
  - `UART_DATA_W`=8.
  - State encoding constants: IDLE=0, WAIT_BUSY=1, WAIT_DONE=2, HOLD=3.
- One sub-module `uart_rr_pick`: combinational round-robin selector. Inputs are `req`, `ptr`, and `mask_en`; outputs are winner index and `valid`.
- FSM, counter, capture registers, and `ptr` live in `uart_tx_arbiter`.
- Top-level instance wires `uart_wr_o`/`uart_dat_o`/`uart_busy_i` to `uart`.

## Test plan
NUM_REQ=4, TIMEOUT=16, real `uart` instance, 20 ns clock.
- Single byte: req0 with 0xFE, last=1. Expect one `uart_wr_o` pulse, `uart_dat_o`=0xFE, `ack_o`=0001 for 1 cycle, 0xFE serialized on `uart_tx`, then `grant_o`=0000 and `ptr`=1.
- Contention: `ptr`=0, req1=0x11 and req3=0x33 raised in the same cycle, both last=1. Expect 0x11 sent, then 0x33, then `ptr`=0.
- Lock: req2 sends 0x41,0x42,0x43 (last on 0x43) while req0=0x55 is pending. Expect three req2 frames before 0x55, and `grant_o`=0100 held throughout.
- Busy timeout: `uart_busy_i` forced 0 and req0 issued. Expect `timeout_o` pulse 16 cycles after `uart_wr_o`, then IDLE, then the next pending requester served.
- Hold timeout: req1 sends 0x20 with last=0, then drops req. Expect `timeout_o` 16 cycles after busy falls, `grant_o`=0000, and `ptr`=2.
- Reset in WAIT_DONE: assert `sys_rst_i` mid-frame. Expect all outputs 0 asynchronously. After release, no `uart_wr_o` until `uart_busy_i`=0.
